// File: rtl/dwb_pkg.sv
// Shared types for the data-cache write buffer: memory-side FSM states,
// buffer entry layout and default geometry.
package dwb_pkg;

  localparam int DWB_DEPTH  = 4;
  // Entry fields are sized for the widest address/data the buffer supports.
  localparam int DWB_ADDR_W = 32;
  localparam int DWB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_READ
  } mem_state_e;

  typedef struct packed {
    logic                  valid;
    logic [DWB_ADDR_W-1:0] addr;
    logic [DWB_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/dwb_match.sv
// Age-ordered word-address compare across the write buffer entries:
// reports a hit, the youngest matching slot, and whether that slot is the head.
module dwb_match #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 30,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  valid,
  input  logic [WORD_W-1:0] entry_word [DEPTH],
  input  logic [PTR_W-1:0]  head_ptr,
  input  logic [WORD_W-1:0] req_word,
  output logic              hit,
  output logic [PTR_W-1:0]  hit_idx,
  output logic              hit_is_head
);

  // Walk from the oldest slot (head) towards the youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PTR_W'(k);
      if (valid[idx] && (entry_word[idx] == req_word)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
    hit_is_head = hit && (hit_idx == head_ptr);
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Write buffer between the data cache and main memory: buffers and coalesces
// writes, forwards buffered data to reads, and drains entries in FIFO order.
module dcache_write_buffer
  import dwb_pkg::*;
#(
  parameter int DEPTH  = DWB_DEPTH,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ready,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              wb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           entries [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  mem_state_e       state;
  mem_state_e       state_next;

  logic [DEPTH-1:0]  entry_valid;
  logic [ADDR_W-3:0] entry_word [DEPTH];
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              hit_is_head;

  logic wr_req, rd_req, rd_hit, rd_miss;
  logic full, head_busy, coalesce, push, pop;
  logic start_drain, start_read, read_done;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = entries[i].valid;
      entry_word[i]  = entries[i].addr[ADDR_W-1:2];
    end
  end

  dwb_match #(
    .DEPTH  (DEPTH),
    .WORD_W (ADDR_W - 2),
    .PTR_W  (PTR_W)
  ) u_match (
    .valid       (entry_valid),
    .entry_word  (entry_word),
    .head_ptr    (head_ptr),
    .req_word    (c_addr[ADDR_W-1:2]),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .hit_is_head (hit_is_head)
  );

  // The cycle carrying c_ready belongs to the previous request, so it is ignored.
  assign wr_req  = c_write && !c_ready;
  assign rd_req  = c_read && !c_write && !c_ready;
  assign rd_hit  = rd_req && hit;
  assign rd_miss = rd_req && !hit;
  assign full    = (count == CNT_W'(DEPTH));
  assign pop     = (state == ST_DRAIN) && m_ready;

  // The head is latched into m_addr/m_wdata when a drain starts, so it must not
  // be coalesced into from that cycle onwards.
  assign head_busy = (state == ST_DRAIN) || start_drain;
  assign coalesce  = wr_req && hit && !(hit_is_head && head_busy);
  assign push      = wr_req && !coalesce && (!full || pop);

  assign wb_empty = (count == '0) && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_drain = 1'b0;
    start_read  = 1'b0;
    read_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_miss) begin
          state_next = ST_READ;
          start_read = 1'b1;
        end else if (count != '0) begin
          state_next  = ST_DRAIN;
          start_drain = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (m_ready) state_next = ST_IDLE;
      end
      ST_READ: begin
        if (m_ready) begin
          state_next = ST_IDLE;
          read_done  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A pop clears the head before a push may reuse the same slot when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (pop) begin
        entries[head_ptr].valid <= 1'b0;
        head_ptr <= head_ptr + 1'b1;
      end
      if (coalesce) entries[hit_idx].data <= DWB_DATA_W'(c_wdata);
      if (push) begin
        entries[tail_ptr] <= '{valid: 1'b1, addr: DWB_ADDR_W'(c_addr), data: DWB_DATA_W'(c_wdata)};
        tail_ptr <= tail_ptr + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_ready <= 1'b0;
      c_rdata <= '0;
      m_read  <= 1'b0;
      m_write <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      c_ready <= coalesce || push || rd_hit || read_done;
      if (rd_hit)         c_rdata <= entries[hit_idx].data[DATA_W-1:0];
      else if (read_done) c_rdata <= m_rdata;
      if (start_drain) begin
        m_write <= 1'b1;
        m_addr  <= entries[head_ptr].addr[ADDR_W-1:0];
        m_wdata <= entries[head_ptr].data[DATA_W-1:0];
      end else if (start_read) begin
        m_read <= 1'b1;
        m_addr <= c_addr;
      end
      if (pop)       m_write <= 1'b0;
      if (read_done) m_read  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: a scoreboard of expected memory
// transactions and read data, with a 3-cycle-latency stallable memory model.
module tb_dcache_write_buffer;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_read, c_write;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        c_ready;
  logic        m_read, m_write;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b0;
  logic        wb_empty;

  int tests = 0;
  int fails = 0;
  int lat;
  int snap;
  int wait_cnt = 0;
  int req_cycles = 0;
  int mrd_cycles = 0;
  logic mem_stall = 1'b0;

  mem_txn_t    exp_mem_q [$];
  logic [31:0] rd_q [$];
  logic [31:0] mem [logic [31:0]];
  mem_txn_t    mm_e;

  dcache_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .c_read   (c_read),
    .c_write  (c_write),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_rdata  (c_rdata),
    .c_ready  (c_ready),
    .m_read   (m_read),
    .m_write  (m_write),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .wb_empty (wb_empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Memory answers 3 cycles after a request; mem_stall freezes the countdown.
  always @(negedge clk) begin
    m_ready = 1'b0;
    if (!rst && (m_read || m_write)) req_cycles++;
    if (!rst && m_read) mrd_cycles++;
    if (rst || !(m_read || m_write)) begin
      wait_cnt = 0;
    end else if (!mem_stall) begin
      wait_cnt++;
      if (wait_cnt == 3) begin
        wait_cnt = 0;
        m_ready  = 1'b1;
        checkOutput("mem_excl", 64'(m_read && m_write), 0);
        checkOutput("mem_expected_txn", 64'(exp_mem_q.size() != 0), 1);
        if (exp_mem_q.size() != 0) begin
          mm_e = exp_mem_q.pop_front();
          checkOutput("mem_txn", {31'b0, m_write, m_addr}, {31'b0, mm_e.wr, mm_e.addr});
          checkOutput("mem_wdata", 64'(m_write ? m_wdata : 32'h0), 64'(mm_e.data));
        end
        if (m_write) mem[m_addr] = m_wdata;
        else if (mem.exists(m_addr)) m_rdata = mem[m_addr];
        else m_rdata = m_addr ^ 32'hC0DE0000;
      end
    end
  end

  task automatic applyStimulus(input string tag, input logic wr, input logic rd,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int max_cycles, output int n);
    logic [31:0] exp_rd;
    c_write = wr;
    c_read  = rd;
    c_addr  = addr;
    c_wdata = data;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!c_ready && n < max_cycles);
    checkOutput({tag, "_ready"}, 64'(c_ready), 1);
    if (rd && !wr && rd_q.size() != 0) begin
      exp_rd = rd_q.pop_front();
      if (c_ready) checkOutput({tag, "_rdata"}, 64'(c_rdata), 64'(exp_rd));
    end
    c_write = 1'b0;
    c_read  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic waitEmpty(input string tag, input int max_cycles);
    int n = 0;
    while (!wb_empty && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, 64'(wb_empty), 1);
    checkOutput({tag, "_sb"}, 64'(exp_mem_q.size()), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0;
    mem[32'h300] = 32'h55;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_c_ready", 64'(c_ready), 0);
    checkOutput("rst_m_read", 64'(m_read), 0);
    checkOutput("rst_m_write", 64'(m_write), 0);
    checkOutput("rst_c_rdata", 64'(c_rdata), 0);
    checkOutput("rst_m_addr", 64'(m_addr), 0);
    checkOutput("rst_m_wdata", 64'(m_wdata), 0);
    checkOutput("rst_wb_empty", 64'(wb_empty), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single write accepted in N+1, then drained to memory.
    exp_mem_q.push_back('{1'b1, 32'h100, 32'hAAAA0001});
    applyStimulus("w100", 1, 0, 32'h100, 32'hAAAA0001, 10, lat);
    checkOutput("w100_lat", 64'(lat), 1);
    checkOutput("w100_busy", 64'(wb_empty), 0);
    waitEmpty("w100_empty", 40);

    // Read forwarded from the buffer without touching memory.
    exp_mem_q.push_back('{1'b1, 32'h200, 32'h11});
    applyStimulus("w200", 1, 0, 32'h200, 32'h11, 10, lat);
    snap = mrd_cycles;
    rd_q.push_back(32'h11);
    applyStimulus("r200", 0, 1, 32'h200, 32'h0, 10, lat);
    checkOutput("r200_lat", 64'(lat), 1);
    waitEmpty("r200_empty", 40);
    checkOutput("r200_no_mread", 64'(mrd_cycles - snap), 0);

    // Read and write together behave as a write.
    exp_mem_q.push_back('{1'b1, 32'h600, 32'h66});
    applyStimulus("rw600", 1, 1, 32'h600, 32'h66, 10, lat);
    checkOutput("rw600_lat", 64'(lat), 1);
    waitEmpty("rw600_empty", 40);

    // Read miss from idle: c_ready the cycle after m_ready.
    exp_mem_q.push_back('{1'b0, 32'h700, 32'h0});
    rd_q.push_back(32'hC0DE0700);
    applyStimulus("r700", 0, 1, 32'h700, 32'h0, 20, lat);
    checkOutput("r700_lat", 64'(lat), 4);
    waitEmpty("r700_empty", 40);

    // A popped entry is no longer forwarded; memory returns the drained value.
    exp_mem_q.push_back('{1'b0, 32'h100, 32'h0});
    rd_q.push_back(32'hAAAA0001);
    applyStimulus("r100", 0, 1, 32'h100, 32'h0, 20, lat);
    waitEmpty("r100_empty", 40);

    // Fill with memory stalled; fifth write waits for the first pop.
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_mem_q.push_back('{1'b1, 32'(i * 4), 32'(32'hD0 + i)});
      applyStimulus("wfill", 1, 0, 32'(i * 4), 32'(32'hD0 + i), 10, lat);
      checkOutput("wfill_lat", 64'(lat), 1);
    end
    exp_mem_q.push_back('{1'b1, 32'h10, 32'hD4});
    fork
      applyStimulus("wfull", 1, 0, 32'h10, 32'hD4, 40, lat);
      begin
        repeat (5) @(posedge clk);
        mem_stall = 1'b0;
      end
    join
    checkOutput("wfull_lat", 64'(lat), 8);
    waitEmpty("wfull_empty", 100);

    // Coalesce into a non-head entry: one memory write carrying the new data.
    mem_stall = 1'b1;
    exp_mem_q.push_back('{1'b1, 32'h500, 32'h7});
    applyStimulus("w500", 1, 0, 32'h500, 32'h7, 10, lat);
    exp_mem_q.push_back('{1'b1, 32'h40, 32'h2});
    applyStimulus("w40a", 1, 0, 32'h40, 32'h1, 10, lat);
    applyStimulus("w40b", 1, 0, 32'h42, 32'h2, 10, lat);
    checkOutput("w40b_lat", 64'(lat), 1);
    rd_q.push_back(32'h2);
    applyStimulus("r40", 0, 1, 32'h40, 32'h0, 10, lat);
    mem_stall = 1'b0;
    waitEmpty("w40_empty", 60);

    // The draining head is not coalesced into; the youngest copy is forwarded.
    mem_stall = 1'b1;
    exp_mem_q.push_back('{1'b1, 32'h900, 32'h1});
    applyStimulus("w900a", 1, 0, 32'h900, 32'h1, 10, lat);
    exp_mem_q.push_back('{1'b1, 32'h900, 32'h2});
    applyStimulus("w900b", 1, 0, 32'h900, 32'h2, 10, lat);
    rd_q.push_back(32'h2);
    applyStimulus("r900", 0, 1, 32'h900, 32'h0, 10, lat);
    checkOutput("r900_lat", 64'(lat), 1);
    mem_stall = 1'b0;
    waitEmpty("w900_empty", 60);

    // Read miss during a drain is served before the remaining entries.
    mem_stall = 1'b1;
    exp_mem_q.push_back('{1'b1, 32'h80, 32'h80A});
    applyStimulus("w80", 1, 0, 32'h80, 32'h80A, 10, lat);
    applyStimulus("w84", 1, 0, 32'h84, 32'h84B, 10, lat);
    exp_mem_q.push_back('{1'b0, 32'h300, 32'h0});
    exp_mem_q.push_back('{1'b1, 32'h84, 32'h84B});
    rd_q.push_back(32'h55);
    fork
      applyStimulus("r300", 0, 1, 32'h300, 32'h0, 60, lat);
      begin
        repeat (3) @(posedge clk);
        mem_stall = 1'b0;
      end
    join
    waitEmpty("r300_empty", 60);

    // Reset mid-drain drops the transaction and every buffered entry.
    mem_stall = 1'b1;
    applyStimulus("wA00", 1, 0, 32'hA00, 32'h1, 10, lat);
    applyStimulus("wA04", 1, 0, 32'hA04, 32'h2, 10, lat);
    applyStimulus("wA08", 1, 0, 32'hA08, 32'h3, 10, lat);
    checkOutput("pre_rst_m_write", 64'(m_write), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_m_write", 64'(m_write), 0);
    checkOutput("mid_rst_m_read", 64'(m_read), 0);
    checkOutput("mid_rst_wb_empty", 64'(wb_empty), 1);
    checkOutput("mid_rst_c_rdata", 64'(c_rdata), 0);
    checkOutput("mid_rst_m_addr", 64'(m_addr), 0);
    snap = req_cycles;
    rst = 1'b0;
    mem_stall = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("post_rst_no_req", 64'(req_cycles - snap), 0);
    checkOutput("post_rst_wb_empty", 64'(wb_empty), 1);
    checkOutput("post_rst_sb", 64'(exp_mem_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_write_buffer.md
DCACHE_WRITE_BUFFER -- requirements
Module: dcache_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered write entries (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter DATA_W, default 32, word width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 c_read  input  1  read request from data cache, level, held until c_ready.
REQ-007 c_write  input  1  write request from data cache, level, held until c_ready.
REQ-008 c_addr  input  ADDR_W  request byte address; bits [1:0] ignored for matching.
REQ-009 c_wdata  input  DATA_W  write data.
REQ-010 c_rdata  output  DATA_W  read data, valid when c_ready=1 for a read.
REQ-011 c_ready  output  1  one-cycle completion pulse to the cache.
REQ-012 m_read  output  1  read request to main memory, held until m_ready.
REQ-013 m_write  output  1  write request to main memory, held until m_ready.
REQ-014 m_addr  output  ADDR_W  memory address.
REQ-015 m_wdata  output  DATA_W  memory write data.
REQ-016 m_rdata  input  DATA_W  memory read data, valid with m_ready.
REQ-017 m_ready  input  1  one-cycle completion pulse from memory.
REQ-018 wb_empty  output  1  high when no entries are buffered and no memory transaction is in flight.

Function
REQ-019 Requests seen while c_ready=1 SHALL be ignored (the cache drops its request that cycle); c_read and c_write both high SHALL be treated as c_write only.
REQ-020 Write, buffer not full: SHALL push {addr, data} at the end of request cycle N and pulse c_ready in N+1.
REQ-021 Write whose word address matches a valid entry other than the one currently being drained SHALL overwrite that entry's data (coalesce), same N+1 timing, no new entry allocated.
REQ-022 Write while full with no coalesce target: c_ready SHALL stay low; accepted in the cycle a slot frees (a push and a pop in the same cycle are both allowed).
REQ-023 Read hitting a buffered word address SHALL return the youngest matching entry's data with c_ready in N+1, without any memory access.
REQ-024 Read miss SHALL be forwarded to memory; c_rdata SHALL equal m_rdata registered, with c_ready in the cycle after m_ready.
REQ-025 Memory-side FSM states: IDLE, DRAIN, READ.
REQ-026 IDLE: pending read miss -> READ (read has priority); else buffer non-empty -> DRAIN (head entry); else stay in IDLE.
REQ-027 DRAIN: m_write=1 with the head entry's address and data held stable; on m_ready, pop the head -> IDLE.
REQ-028 READ: m_read=1 with c_addr held stable; on m_ready, capture data -> IDLE.
REQ-029 A read arriving during DRAIN SHALL wait for that drain to complete and SHALL then be served before the next drain.
REQ-030 The head entry SHALL remain forwardable until it is popped.
REQ-031 Entries SHALL drain in FIFO order; pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from a count of width log2(DEPTH)+1.
REQ-032 m_read and m_write SHALL never be high simultaneously.

Reset
REQ-033 On rst, the block SHALL invalidate all entries, zero the count and pointers, set the FSM to IDLE, drive c_ready, m_read and m_write to 0, drive c_rdata, m_addr and m_wdata to 0, and drive wb_empty to 1.
REQ-034 A reset during DRAIN or READ SHALL drop the transaction: m_read and m_write are low in the cycle after the reset edge, and buffered data is lost.

Structure
REQ-035 A shared package dwb_pkg SHALL hold the FSM state enum, the entry struct {valid, addr, data} and the default DEPTH.
REQ-036 One sub-module, dwb_match, SHALL perform the combinational age-ordered address compare, giving hit, youngest index, and whether the hit is the head entry.

Verification (memory model: m_ready 3 cycles after request)
REQ-037 Write 0x100<-0xAAAA0001 -> c_ready at N+1; m_write at 0x100 follows; wb_empty=1 after m_ready.
REQ-038 Write 0x200<-0x11, then read 0x200 before it drains -> c_rdata=0x11 at N+1, and m_read stays 0.
REQ-039 Five writes to 0x0, 0x4, 0x8, 0xC, 0x10 with memory stalled -> the fifth write's c_ready is withheld until the first m_ready, then accepted; memory sees the five addresses in order.
REQ-040 Write 0x40<-1, write 0x40<-2 while 0x40 is not the head -> a single entry with data 2 is held; exactly one m_write of value 2.
REQ-041 During DRAIN of 0x80, read miss 0x300 (memory holds 0x55) -> the read issues right after the drain's m_ready, c_rdata=0x55, and the remaining entries drain afterwards.
REQ-042 Assert rst mid-DRAIN with 3 entries buffered -> m_write=0 in the next cycle, wb_empty=1, and no further memory requests.
